// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: operation encodings and default width shared by the Y86 ALU files.
`default_nettype none

package y86_alu_pkg;

  localparam int unsigned ALU_DEFAULT_WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_addsub64.sv
// alu_addsub64: combinational adder/subtractor producing sum, carry-out and signed overflow.
`default_nettype none

module alu_addsub64
  import y86_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  // Subtract as a + ~b + 1, so carry = 1 means no borrow.
  assign b_eff    = sub ? ~b : b;
  assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];

  // Overflow seen at the adder's own inputs covers both add and sub.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/y86_alu.sv
// y86_alu: registered 64-bit add/sub/and/xor ALU for the Y86 execute stage.
// Define ALU_CC_EN to keep the zf/sf/of condition-code registers; otherwise they read as 0.
`default_nettype none

module y86_alu
  import y86_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_en,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_carry_out,
  output logic             alu_overflow_check,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_overflow;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  alu_addsub64 #(.WIDTH(WIDTH)) u_addsub (
    .a        (input1),
    .b        (input2),
    .sub      (control == ALU_SUB),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_overflow)
  );

  always_comb begin
    result   = as_sum;
    carry    = 1'b0;
    overflow = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: begin
        carry    = as_carry;
        overflow = as_overflow;
      end
      ALU_AND: result = input1 & input2;
      default: result = input1 ^ input2;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_out            <= '0;
      alu_carry_out      <= 1'b0;
      alu_overflow_check <= 1'b0;
    end else if (alu_en) begin
      alu_out            <= result;
      alu_carry_out      <= carry;
      alu_overflow_check <= overflow;
    end
  end

`ifdef ALU_CC_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      zf <= 1'b0;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (alu_en) begin
      zf <= (result == '0);
      sf <= result[WIDTH-1];
      of <= overflow;
    end
  end
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_alu.sv
// tb_y86_alu: directed vector table, hold/reset sequences and randomized checks against a reference model.
`default_nettype none

module tb_y86_alu;
  import y86_alu_pkg::*;

`ifdef ALU_CC_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  typedef struct {
    logic [1:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        carry;
    logic        ovf;
    logic        zf;
    logic        sf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, alu_en;
  logic [1:0]  control;
  logic [63:0] input1, input2;
  logic [63:0] alu_out;
  logic        alu_carry_out, alu_overflow_check, zf, sf, of;

  int n_checks = 0;
  int n_fail   = 0;

  y86_alu #(.WIDTH(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .alu_en             (alu_en),
    .control            (control),
    .input1             (input1),
    .input2             (input2),
    .alu_out            (alu_out),
    .alu_carry_out      (alu_carry_out),
    .alu_overflow_check (alu_overflow_check),
    .zf                 (zf),
    .sf                 (sf),
    .of                 (of)
  );

  always #5 clock = ~clock;

  // Reference: plain unsigned/signed arithmetic with range checks.
  function automatic vec_t model(logic [1:0] c, logic [63:0] a, logic [63:0] b);
    vec_t r;
    logic [64:0]        u;
    logic signed [65:0] s;
    r.c = c; r.a = a; r.b = b; r.carry = 1'b0; r.ovf = 1'b0;
    s = '0;
    case (c)
      2'd0: begin
        u = {1'b0, a} + {1'b0, b};
        r.out = u[63:0];
        r.carry = u[64];
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        r.ovf = (s != {{2{s[63]}}, s[63:0]});
      end
      2'd1: begin
        r.out = a - b;
        r.carry = (a >= b);
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        r.ovf = (s != {{2{s[63]}}, s[63:0]});
      end
      2'd2: r.out = a & b;
      default: r.out = a ^ b;
    endcase
    r.zf = (r.out == 64'd0);
    r.sf = r.out[63];
    return r;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(string name, vec_t e);
    check({name, ".out"},   alu_out, e.out);
    check({name, ".carry"}, 64'(alu_carry_out), 64'(e.carry));
    check({name, ".ovf"},   64'(alu_overflow_check), 64'(e.ovf));
    check({name, ".zf"},    64'(zf), 64'(e.zf & CC));
    check({name, ".sf"},    64'(sf), 64'(e.sf & CC));
    check({name, ".of"},    64'(of), 64'(e.ovf & CC));
  endtask

  task automatic drive(logic [1:0] c, logic [63:0] a, logic [63:0] b, logic en, logic rst);
    @(negedge clock);
    control = c; input1 = a; input2 = b; alu_en = en; reset = rst;
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[8];
  vec_t zero_v;
  vec_t held;

  initial begin
    vecs[0] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'd2, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    zero_v  = '{2'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; alu_en = 1'b0; control = 2'd0; input1 = '0; input2 = '0;
    drive(2'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(2'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    check_all("reset", zero_v);

    // Directed table, applied back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].c, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Hold: disable and churn operands for three cycles.
    drive(2'd1, 64'd3, 64'd5, 1'b1, 1'b0);
    held = model(2'd1, 64'd3, 64'd5);
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 64'h1234 + 64'(i), 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      check_all($sformatf("hold%0d", i), held);
    end

    // Reset wins over enable and discards the capture.
    drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1);
    check_all("rst_en", zero_v);

    // Reset in the middle of back-to-back operations.
    drive(2'd0, 64'd10, 64'd20, 1'b1, 1'b0);
    check_all("b2b0", model(2'd0, 64'd10, 64'd20));
    drive(2'd1, 64'd0, 64'd1, 1'b1, 1'b1);
    check_all("b2b_rst", zero_v);
    drive(2'd3, 64'hAAAA, 64'h5555, 1'b0, 1'b0);
    check_all("post_rst_hold", zero_v);
    drive(2'd3, 64'hAAAA, 64'h5555, 1'b1, 1'b0);
    check_all("post_rst_op", model(2'd3, 64'hAAAA, 64'h5555));

    // Randomized operations with boundary-biased operands and random enables.
    held = model(2'd3, 64'hAAAA, 64'h5555);
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  c;
      logic [63:0] a, b;
      logic        en;
      c  = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, {63{$urandom_range(0, 1) == 1}}};
      if ($urandom_range(0, 3) == 0) b = (c == 2'd1) ? a : 64'(b[1:0]);
      en = ($urandom_range(0, 4) != 0);
      drive(c, a, b, en, 1'b0);
      if (en) held = model(c, a, b);
      check_all($sformatf("rnd%0d", i), held);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
